// File: rtl/icache_controller_if.sv
// icache_controller_if: CPU fetch, instruction-memory and counter signals; master = cache side, slave = CPU/memory side
interface icache_controller_if;
  logic         read;
  logic [9:0]   pc;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
  modport master (
    input  read, pc, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address, hit_count, miss_count
  );
  modport slave (
    output read, pc, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address, hit_count, miss_count
  );
endinterface

// File: rtl/icache_controller.sv
// icache_controller: 8x16B direct-mapped instruction cache with refill FSM and saturating hit/miss counters; ports clock, reset (async active-low), bus
module icache_controller (
  input logic clock,
  input logic reset,
  icache_controller_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, REFILL} state_t;
  state_t state, next_state;
  logic [7:0] valid;
  logic [2:0] tags [8];
  logic [127:0] data [8];
  logic [127:0] buffer;
  logic [5:0] miss_addr;
  logic [15:0] hit_count, miss_count;
  logic fetch_armed, replay, hit, unused_pc;
  assign unused_pc = ^bus.pc[1:0];
  assign hit = valid[bus.pc[6:4]] & (tags[bus.pc[6:4]] == bus.pc[9:7]);
  assign bus.instruction = data[bus.pc[6:4]][{bus.pc[3:2], 5'b0} +: 32];
  assign bus.hit_count = hit_count;
  assign bus.miss_count = miss_count;
  always_comb begin
    next_state = state;
    bus.busywait = 1'b1;
    bus.mem_read = 1'b0;
    bus.mem_address = miss_addr;
    case (state)
      IDLE: begin
        bus.busywait = bus.read & ~hit;
        bus.mem_address = bus.pc[9:4];
        next_state = (bus.read & ~hit) ? FETCH : IDLE;
      end
      FETCH: begin
        bus.mem_read = 1'b1;
        next_state = (fetch_armed & ~bus.mem_busywait) ? REFILL : FETCH;
      end
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      valid <= '0;
      fetch_armed <= 1'b0;
      replay <= 1'b0;
      miss_addr <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      fetch_armed <= state == FETCH;
      replay <= state == REFILL;
      if (state == IDLE && next_state == FETCH) begin
        miss_addr <= bus.pc[9:4];
        miss_count <= miss_count + {15'b0, ~&miss_count};
      end
      if (state == IDLE && bus.read && hit && !replay) hit_count <= hit_count + {15'b0, ~&hit_count};
      if (state == REFILL) valid[miss_addr[2:0]] <= 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (state == FETCH && next_state == REFILL) buffer <= bus.mem_readdata;
    if (state == REFILL) begin
      tags[miss_addr[2:0]] <= miss_addr[5:3];
      data[miss_addr[2:0]] <= buffer;
    end
  end
endmodule

// File: tb/tb_icache_controller.sv
// tb_icache_controller: directed fetch sequences checked every cycle against a block-level cache model
module tb_icache_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  icache_controller_if bus();
  icache_controller dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int n_chk = 0;
  int n_pass = 0;
  int lat = 2;
  logic [31:0] imem [256];
  bit mv [8];
  logic [2:0] mt [8];
  int k = -1;
  bit replay = 1'b0;
  logic [5:0] mblk = '0;
  int eh = 0;
  int em = 0;
  bit mact = 1'b0;
  int mcnt = 0;
  logic [5:0] maddr = '0;
  function automatic logic [127:0] block(input logic [5:0] b);
    return {imem[{b, 2'd3}], imem[{b, 2'd2}], imem[{b, 2'd1}], imem[{b, 2'd0}]};
  endfunction
  function automatic bit present(input logic [9:0] a);
    return mv[a[6:4]] && (mt[a[6:4]] == a[9:7]);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  // Instruction memory: busy from the cycle after it sees mem_read for lat cycles, garbage data until it drops.
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      mact = 1'b0;
      bus.mem_busywait = 1'b0;
    end else if (mact) begin
      mcnt--;
      if (mcnt == 0) begin
        bus.mem_busywait = 1'b0;
        bus.mem_readdata = block(maddr);
        mact = 1'b0;
      end
    end else if (bus.mem_read) begin
      mact = 1'b1;
      mcnt = lat;
      maddr = bus.mem_address;
      bus.mem_busywait = 1'b1;
      bus.mem_readdata = {4{32'hDEADBEEF}};
    end
  end
  // Cache model: line presence plus a cycle count through the 1 + lat + 1 miss penalty.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      foreach (mv[i]) mv[i] = 1'b0;
      k = -1;
      replay = 1'b0;
      eh = 0;
      em = 0;
    end else if (k >= 0 && k < lat + 2) begin
      k++;
    end else if (k >= 0) begin
      mv[mblk[2:0]] = 1'b1;
      mt[mblk[2:0]] = mblk[5:3];
      k = -1;
      replay = 1'b1;
    end else begin
      if (bus.read && present(bus.pc) && !replay && eh < 65535) eh++;
      if (bus.read && !present(bus.pc)) begin
        if (em < 65535) em++;
        k = 1;
        mblk = bus.pc[9:4];
      end
      replay = 1'b0;
    end
  end
  always @(negedge clock) begin
    logic eb;
    eb = (k < 0) ? (bus.read && !present(bus.pc)) : 1'b1;
    chk("busywait", 32'(bus.busywait), 32'(eb));
    chk("mem_read", 32'(bus.mem_read), 32'(k >= 1 && k <= lat + 1));
    chk("mem_address", 32'(bus.mem_address), 32'((k < 0) ? bus.pc[9:4] : mblk));
    chk("hit_count", 32'(bus.hit_count), 32'(eh));
    chk("miss_count", 32'(bus.miss_count), 32'(em));
    if (bus.read && !eb) chk("instruction", bus.instruction, imem[bus.pc[9:2]]);
  end
  task automatic fetch(input logic [9:0] a, output int st, output logic [31:0] ins, output int ma);
    bus.read = 1'b1;
    bus.pc = a;
    st = 0;
    ma = -1;
    @(negedge clock);
    while (bus.busywait && st < 100) begin
      if (bus.mem_read && ma < 0) ma = int'(bus.mem_address);
      st++;
      @(negedge clock);
    end
    if (st >= 100) chk("fetch_timeout", 32'(bus.busywait), 32'd0);
    ins = bus.instruction;
    @(posedge clock);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int st, ma;
    logic [31:0] ins;
    foreach (imem[i]) imem[i] = 32'(i) * 32'h9E3779B9 ^ 32'h13572468;
    imem[0] = 32'h00010001;
    imem[1] = 32'h00020002;
    imem[3] = 32'h02050302;
    imem[4] = 32'h03040501;
    imem[5] = 32'h02060504;
    bus.read = 1'b0;
    bus.pc = '0;
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busywait_idle", 32'(bus.busywait), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_hit_count", 32'(bus.hit_count), 32'd0);
    chk("rst_miss_count", 32'(bus.miss_count), 32'd0);
    bus.read = 1'b1;
    #1;
    chk("rst_busywait_eq_read", 32'(bus.busywait), 32'd1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    fetch(10'h000, st, ins, ma);
    chk("cold_stall", 32'(st), 32'd5);
    chk("cold_mem_address", 32'(ma), 32'd0);
    chk("cold_instruction", ins, 32'h00010001);
    chk("cold_miss_count", 32'(bus.miss_count), 32'd1);
    chk("cold_replay_hit_count", 32'(bus.hit_count), 32'd0);
    fetch(10'h004, st, ins, ma);
    chk("hit004_stall", 32'(st), 32'd0);
    chk("hit004_instruction", ins, 32'h00020002);
    fetch(10'h00C, st, ins, ma);
    chk("hit00c_stall", 32'(st), 32'd0);
    chk("hit00c_instruction", ins, 32'h02050302);
    chk("same_block_hit_count", 32'(bus.hit_count), 32'd2);
    fetch(10'h010, st, ins, ma);
    chk("miss010_stall", 32'(st), 32'd5);
    chk("miss010_mem_address", 32'(ma), 32'd1);
    chk("miss010_instruction", ins, 32'h03040501);
    fetch(10'h014, st, ins, ma);
    chk("hit014_stall", 32'(st), 32'd0);
    chk("hit014_instruction", ins, 32'h02060504);
    fetch(10'h080, st, ins, ma);
    chk("conflict080_stall", 32'(st), 32'd5);
    chk("conflict080_mem_address", 32'(ma), 32'd8);
    fetch(10'h000, st, ins, ma);
    chk("evicted000_stall", 32'(st), 32'd5);
    chk("evicted000_mem_address", 32'(ma), 32'd0);
    chk("evicted000_instruction", ins, 32'h00010001);
    chk("conflict_miss_count", 32'(bus.miss_count), 32'd4);
    chk("conflict_hit_count", 32'(bus.hit_count), 32'd3);
    lat = 5;
    fetch(10'h0A0, st, ins, ma);
    chk("lat5_stall_after_detect", 32'(st - 1), 32'd7);
    chk("lat5_mem_address", 32'(ma), 32'd10);
    bus.read = 1'b1;
    bus.pc = 10'h040;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("rstmid_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rstmid_busywait", 32'(bus.busywait), 32'd1);
    chk("rstmid_miss_count", 32'(bus.miss_count), 32'd0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    lat = 2;
    fetch(10'h000, st, ins, ma);
    chk("after_rst_stall", 32'(st), 32'd5);
    chk("after_rst_instruction", ins, 32'h00010001);
    chk("after_rst_miss_count", 32'(bus.miss_count), 32'd1);
    bus.read = 1'b1;
    bus.pc = 10'h004;
    repeat (65540) @(posedge clock);
    #1;
    chk("hit_saturated", 32'(bus.hit_count), 32'hFFFF);
    bus.read = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("no_read_busywait", 32'(bus.busywait), 32'd0);
    chk("no_read_hit_count", 32'(bus.hit_count), 32'hFFFF);
    chk("no_read_miss_count", 32'(bus.miss_count), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/icache_controller.md
# icache_controller

Direct-mapped instruction cache and refill sequencer between the CPU fetch stage and the 16-byte-block instruction memory. It holds 8 blocks of 16 bytes. Hits are served combinationally with no stall. On a miss it stalls the CPU, reads the whole block from instruction memory through the memory's read/busywait handshake, installs the block, then resumes. It also keeps saturating hit and miss counters for performance measurement.

## Interface
- Parameters: none. Geometry is fixed: 8 lines × 16 B, 10-bit byte address space, 32-bit instructions.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- read  in  1  CPU fetch request.
- pc  in  10  CPU byte address; bits [1:0] ignored.
- instruction  out  32  fetched instruction word.
- busywait  out  1  stall to CPU.
- mem_read  out  1  read request to instruction memory.
- mem_address  out  6  block address to memory (pc[9:4]).
- mem_readdata  in  128  block from memory; byte k at bits [8k+7:8k].
- mem_busywait  in  1  memory busy.
- hit_count  out  16  saturating count of hits.
- miss_count  out  16  saturating count of misses.

## Operation
- Address split: tag = pc[9:7], index = pc[6:4], word offset = pc[3:2].
- Per line: valid (1 b), tag (3 b), data (128 b).
- hit = valid[index] & (tag[index] == pc tag).
- instruction is data[index] word[offset], i.e. bits [32·offset+31 : 32·offset]. Little-endian byte order within the word. It is driven combinationally from the array and is valid whenever hit is 1.
- FSM states: IDLE, FETCH, REFILL.
  - IDLE: busywait = read & ~hit. If read & ~hit, latch pc[9:4] into the miss-address register and go to FETCH.
  - FETCH: mem_read = 1; mem_address = latched block address; busywait = 1.
    - mem_busywait is ignored on the first FETCH cycle, because the memory raises it in response to mem_read.
    - From the second FETCH cycle on, at a posedge with mem_busywait = 0: capture mem_readdata into the refill buffer and go to REFILL.
  - REFILL: mem_read = 0; busywait = 1. At posedge, write the buffer into the line at the latched index, set tag = latched tag and valid = 1, then go to IDLE.
- mem_address equals the latched block address in FETCH and REFILL, and pc[9:4] in IDLE.
- Counters:
  - miss_count increments on each IDLE→FETCH transition.
  - hit_count increments on each posedge in IDLE with read & hit, except the first IDLE cycle after REFILL (the replayed fetch is already counted as a miss).
  - Both saturate at 0xFFFF.
- The CPU holds pc and read stable while busywait = 1. pc changes during FETCH/REFILL are ignored because the latched address is used.

## Timing
- Reset values:
  - state = IDLE, all valid = 0, counters = 0, mem_read = 0.
  - busywait = read, since every line is invalid.
  - instruction is don't-care while valid = 0 (tag/data arrays are not reset).
- Hit latency: 0 cycles; instruction is valid in the same cycle as pc.
- Miss penalty: 1 (first FETCH cycle) + N (cycles mem_busywait stays high after that) + 1 (REFILL). busywait drops in the first IDLE cycle after REFILL, where the fetch hits.
- A conflict miss overwrites the line unconditionally; the cache holds no dirty state.
- read = 0 in IDLE: no transition, no count, busywait = 0.
- Reset asserted mid-FETCH or mid-REFILL: the FSM returns to IDLE at once, mem_read drops at once, no line is written, and all valid bits are cleared.
- Counter at 0xFFFF with a further event: it holds 0xFFFF.

## Test plan
- Cold miss: release reset, read = 1, pc = 0x000 -> miss_count = 1, mem_read high with mem_address = 0; after the memory completes, instruction = 0x00010001 and busywait = 0; hit_count stays 0 on the replay cycle.
- Same-block hits: pc = 0x004, then 0x00C -> instruction = 0x00020002, then 0x02050302; busywait is never high; hit_count = 2.
- Next block: pc = 0x010 -> miss, mem_address = 1, instruction = 0x03040501; pc = 0x014 -> 0x02060504 on a hit.
- Conflict eviction: pc = 0x080 (index 0, tag 1) -> miss, mem_address = 8; then pc = 0x000 -> miss again, mem_address = 0; miss_count increases by 2.
- Reset during FETCH (mem_busywait still high) -> mem_read = 0 and busywait = read immediately; a following read of pc = 0x000 misses.
- Memory model holding mem_busywait high for 5 cycles -> busywait high for exactly 7 cycles from miss detection; mem_readdata is captured only on the edge where mem_busywait = 0.
